// File: rtl/softmax_pkg.sv
// softmax_pkg: row controller state encoding and default sizing
package softmax_pkg;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;
  localparam int C_MAX_DEF = 1024;
  localparam int CNT_W_DEF = 11;
endpackage

// File: rtl/softmax_row_ctrl_watchdog.sv
// sm_watchdog: counts result-idle cycles while enabled, flags the TIMEOUT-th one
module sm_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic kick,
  output logic expired
);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (!rst_n || !en || kick) ? '0 : cnt + TW'(1);
  assign expired = en && !kick && cnt == TW'(TIMEOUT - 1);
endmodule

// File: rtl/softmax_row_ctrl.sv
// softmax_row_ctrl: meters one row of FP32 elements into the softmax pipeline and tracks its drain
module softmax_row_ctrl
  import softmax_pkg::*;
#(
  parameter int C_MAX   = C_MAX_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CNT_W-1:0] cfg_len_i,
  input  logic             up_tvalid_i,
  output logic             up_tready_o,
  input  logic [31:0]      up_tdata_i,
  input  logic             up_tlast_i,
  output logic             dn_tvalid_o,
  input  logic             dn_tready_i,
  output logic [31:0]      dn_tdata_o,
  output logic             dn_tlast_o,
  input  logic             res_valid_i,
  input  logic             res_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_cfg_o,
  output logic             err_len_o,
  output logic             err_tmo_o,
  output logic [CNT_W-1:0] in_cnt_o,
  output logic [CNT_W-1:0] out_cnt_o
);
  state_t state, nxt;
  logic [CNT_W-1:0] len, out_nxt;
  logic idle, load, wait_s, cfg_ok, go, acc, res_hs, res_inc, expired;
  assign idle    = state == S_IDLE;
  assign load    = state == S_LOAD;
  assign wait_s  = state == S_WAIT;
  assign cfg_ok  = cfg_len_i != '0 && {1'b0, cfg_len_i} <= (CNT_W + 1)'(C_MAX);
  assign go      = idle && start_i && cfg_ok;
  assign dn_tvalid_o = load && up_tvalid_i;
  assign up_tready_o = load && dn_tready_i;
  assign dn_tdata_o  = load ? up_tdata_i : '0;
  assign dn_tlast_o  = load && in_cnt_o == len - CNT_W'(1);
  assign acc     = dn_tvalid_o && dn_tready_i;
  assign res_hs  = res_valid_i && res_ready_i;
  assign res_inc = (load || wait_s) && res_hs && out_cnt_o != len;
  assign out_nxt = out_cnt_o + CNT_W'(res_inc);
  assign busy_o  = !idle;
  assign done_o  = state == S_DONE;
  sm_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk(clk), .rst_n(rst_n), .en(wait_s), .kick(res_hs), .expired(expired)
  );
  always_ff @(posedge clk)
    state <= !rst_n ? S_IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = go ? S_LOAD : S_IDLE;
      S_LOAD:  nxt = (acc && dn_tlast_o) ? S_WAIT : S_LOAD;
      S_WAIT:  nxt = out_nxt == len ? S_DONE : expired ? S_IDLE : S_WAIT;
      default: nxt = S_IDLE;
    endcase
  end
  // err_len_o is sticky across the row; only an accepted start clears it, and a new error wins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len       <= '0;
      in_cnt_o  <= '0;
      out_cnt_o <= '0;
      err_cfg_o <= 1'b0;
      err_len_o <= 1'b0;
      err_tmo_o <= 1'b0;
    end else begin
      err_cfg_o <= idle && start_i && !cfg_ok;
      err_tmo_o <= wait_s && expired && out_nxt != len;
      err_len_o <= (err_len_o && !go) || (acc && up_tlast_i != dn_tlast_o)
                   || (res_hs && (!(load || wait_s) || out_cnt_o == len));
      if (go) begin
        len       <= cfg_len_i;
        in_cnt_o  <= '0;
        out_cnt_o <= '0;
      end else begin
        in_cnt_o  <= acc ? in_cnt_o + CNT_W'(1) : in_cnt_o;
        out_cnt_o <= out_nxt;
      end
    end
  end
endmodule

// File: tb/tb_softmax_row_ctrl.sv
// tb_softmax_row_ctrl: directed table-driven checks of the softmax row controller
module tb_softmax_row_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0;
  logic [10:0] cfg_len_i = '0;
  logic up_tvalid_i = 1'b0, up_tlast_i = 1'b0, dn_tready_i = 1'b0;
  logic res_valid_i = 1'b0, res_ready_i = 1'b0;
  logic [31:0] up_tdata_i = '0, dn_tdata_o;
  logic up_tready_o, dn_tvalid_o, dn_tlast_o, busy_o, done_o, err_cfg_o, err_len_o, err_tmo_o;
  logic [10:0] in_cnt_o, out_cnt_o;
  int pass_n = 0, total_n = 0;

  always #5 clk = ~clk;

  softmax_row_ctrl #(.C_MAX(1024), .CNT_W(11), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .cfg_len_i(cfg_len_i),
    .up_tvalid_i(up_tvalid_i), .up_tready_o(up_tready_o), .up_tdata_i(up_tdata_i),
    .up_tlast_i(up_tlast_i), .dn_tvalid_o(dn_tvalid_o), .dn_tready_i(dn_tready_i),
    .dn_tdata_o(dn_tdata_o), .dn_tlast_o(dn_tlast_o), .res_valid_i(res_valid_i),
    .res_ready_i(res_ready_i), .busy_o(busy_o), .done_o(done_o), .err_cfg_o(err_cfg_o),
    .err_len_o(err_len_o), .err_tmo_o(err_tmo_o), .in_cnt_o(in_cnt_o), .out_cnt_o(out_cnt_o)
  );

  // fl = {busy, done, err_cfg, err_len, err_tmo, dn_tvalid, dn_tlast, up_tready}
  typedef struct {
    logic st; logic [10:0] len;
    logic uv, ul, dr, rv, rr, ld;
    logic [7:0] fl; logic [10:0] inc, outc;
  } vec_t;

  function automatic vec_t mk(input logic st, input int len, input logic uv, ul, dr, rv, rr, ld,
                              input logic [7:0] fl, input int inc, input int outc);
    vec_t v;
    v.st = st; v.len = 11'(len); v.uv = uv; v.ul = ul; v.dr = dr; v.rv = rv; v.rr = rr; v.ld = ld;
    v.fl = fl; v.inc = 11'(inc); v.outc = 11'(outc);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [29:0] flags_now;
    return {busy_o, done_o, err_cfg_o, err_len_o, err_tmo_o, dn_tvalid_o, dn_tlast_o, up_tready_o,
            in_cnt_o, out_cnt_o};
  endfunction

  vec_t tbl[38];

  initial begin
    tbl = '{
      mk(1,4,   0,0,0,0,0,0, 8'b00000000, 0,0),
      mk(0,0,   1,0,1,0,0,1, 8'b10000101, 0,0),
      mk(0,0,   1,0,1,1,1,1, 8'b10000101, 1,0),
      mk(0,0,   1,0,1,1,1,1, 8'b10000101, 2,1),
      mk(0,0,   1,1,1,1,1,1, 8'b10000111, 3,2),
      mk(0,0,   0,0,0,0,0,0, 8'b10000000, 4,3),
      mk(0,0,   0,0,0,1,1,0, 8'b10000000, 4,3),
      mk(1,2,   0,0,0,0,0,0, 8'b11000000, 4,4),
      mk(0,0,   0,0,0,0,0,0, 8'b00000000, 4,4),
      mk(1,0,   0,0,0,0,0,0, 8'b00000000, 4,4),
      mk(1,1025,0,0,0,0,0,0, 8'b00100000, 4,4),
      mk(0,0,   0,0,0,0,0,0, 8'b00100000, 4,4),
      mk(0,0,   0,0,0,0,0,0, 8'b00000000, 4,4),
      mk(1,3,   0,0,0,0,0,0, 8'b00000000, 4,4),
      mk(0,0,   1,0,1,0,0,1, 8'b10000101, 0,0),
      mk(0,0,   1,1,1,0,0,1, 8'b10000101, 1,0),
      mk(0,0,   1,0,1,0,0,1, 8'b10010111, 2,0),
      mk(0,0,   0,0,0,1,1,0, 8'b10010000, 3,0),
      mk(0,0,   0,0,0,1,1,0, 8'b10010000, 3,1),
      mk(0,0,   0,0,0,1,1,0, 8'b10010000, 3,2),
      mk(0,0,   0,0,0,0,0,0, 8'b11010000, 3,3),
      mk(0,0,   0,0,0,0,0,0, 8'b00010000, 3,3),
      mk(1,2,   0,0,0,0,0,0, 8'b00010000, 3,3),
      mk(0,0,   1,0,1,0,0,1, 8'b10000101, 0,0),
      mk(0,0,   1,1,0,0,0,1, 8'b10000110, 1,0),
      mk(0,0,   1,1,1,0,0,1, 8'b10000111, 1,0),
      mk(0,0,   1,1,0,0,0,0, 8'b10000000, 2,0),
      mk(0,0,   0,0,0,1,1,0, 8'b10000000, 2,0),
      mk(0,0,   0,0,0,0,0,0, 8'b10000000, 2,1),
      mk(0,0,   0,0,0,0,0,0, 8'b10000000, 2,1),
      mk(0,0,   0,0,0,0,0,0, 8'b10000000, 2,1),
      mk(0,0,   0,0,0,0,0,0, 8'b10000000, 2,1),
      mk(0,0,   0,0,0,0,0,0, 8'b10000000, 2,1),
      mk(0,0,   0,0,0,0,0,0, 8'b10000000, 2,1),
      mk(0,0,   0,0,0,0,0,0, 8'b10000000, 2,1),
      mk(0,0,   0,0,0,0,0,0, 8'b10000000, 2,1),
      mk(0,0,   0,0,0,0,0,0, 8'b00001000, 2,1),
      mk(0,0,   0,0,0,0,0,0, 8'b00000000, 2,1)
    };
    up_tvalid_i = 1'b1;
    dn_tready_i = 1'b1;
    up_tdata_i  = 32'hDEAD_BEEF;
    repeat (2) tick;
    chk("reset_outputs", {flags_now(), dn_tdata_o}, 64'd0);
    rst_n = 1'b1;
    up_tvalid_i = 1'b0;
    dn_tready_i = 1'b0;
    for (int i = 0; i < 38; i++) begin
      start_i     = tbl[i].st;
      cfg_len_i   = tbl[i].len;
      up_tvalid_i = tbl[i].uv;
      up_tlast_i  = tbl[i].ul;
      dn_tready_i = tbl[i].dr;
      res_valid_i = tbl[i].rv;
      res_ready_i = tbl[i].rr;
      up_tdata_i  = 32'hC0DE_0000 + 32'(i);
      #1;
      chk($sformatf("row%0d_ctrl", i), flags_now(), {tbl[i].fl, tbl[i].inc, tbl[i].outc});
      chk($sformatf("row%0d_data", i), dn_tdata_o, tbl[i].ld ? up_tdata_i : 32'd0);
      tick;
    end
    {start_i, up_tvalid_i, up_tlast_i, dn_tready_i, res_valid_i, res_ready_i} = '0;
    start_i   = 1'b1;
    cfg_len_i = 11'd8;
    tick;
    start_i     = 1'b0;
    up_tvalid_i = 1'b1;
    dn_tready_i = 1'b1;
    repeat (5) tick;
    chk("mid_in_cnt", {busy_o, in_cnt_o}, {1'b1, 11'd5});
    rst_n = 1'b0;
    tick;
    chk("mid_reset_outputs", {flags_now(), dn_tdata_o}, 64'd0);
    rst_n = 1'b1;
    up_tvalid_i = 1'b0;
    tick;
    chk("post_reset_quiet", {busy_o, done_o, err_cfg_o, err_len_o, err_tmo_o}, 5'd0);
    start_i   = 1'b1;
    cfg_len_i = 11'd1;
    tick;
    start_i     = 1'b0;
    up_tvalid_i = 1'b1;
    up_tlast_i  = 1'b1;
    #1;
    chk("len1_tlast", {dn_tvalid_o, dn_tlast_o, up_tready_o}, 3'b111);
    tick;
    up_tvalid_i = 1'b0;
    up_tlast_i  = 1'b0;
    res_valid_i = 1'b1;
    res_ready_i = 1'b1;
    tick;
    res_valid_i = 1'b0;
    res_ready_i = 1'b0;
    for (int k = 0; k < 5 && !done_o; k++) tick;
    chk("len1_done", {done_o, in_cnt_o, out_cnt_o}, {1'b1, 11'd1, 11'd1});
    chk("len1_no_err", {err_cfg_o, err_len_o, err_tmo_o}, 3'd0);
    tick;
    chk("len1_idle", {busy_o, done_o}, 2'b00);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/softmax_row_ctrl.md
SOFTMAX_ROW_CTRL -- requirements
Module: softmax_row_ctrl

Interface
REQ-001 SHALL have parameter C_MAX, default 1024, maximum row length in elements.
REQ-002 SHALL have parameter CNT_W, default 11, counter/length width (holds C_MAX).
REQ-003 SHALL have parameter TIMEOUT, default 4096, idle-output cycles in WAIT before abort.
REQ-004 SHALL have ports, one per line:
 clk  in  1  single clock; all logic on its rising edge
 rst_n  in  1  reset, synchronous, active-low
 start_i  in  1  pulse: begin one row
 cfg_len_i  in  CNT_W  row length, sampled on accepted start_i
 up_tvalid_i / up_tready_o / up_tdata_i[31:0] / up_tlast_i  in/out/in/in  FP32 source stream
 dn_tvalid_o / dn_tready_i / dn_tdata_o[31:0] / dn_tlast_o  out/in/out/out  softmax pipeline input stream
 res_valid_i  in  1  pipeline final output valid (monitor only)
 res_ready_i  in  1  consumer ready on final output (monitor only)
 busy_o  out  1  high in any state but IDLE
 done_o  out  1  one-cycle pulse: row fully drained
 err_cfg_o  out  1  one-cycle pulse: start rejected, bad length
 err_len_o  out  1  sticky: upstream tlast mismatch or surplus outputs
 err_tmo_o  out  1  one-cycle pulse: drain timeout abort
 in_cnt_o / out_cnt_o  out  CNT_W  elements forwarded / results observed this row

Function
REQ-005 SHALL implement FSM IDLE, LOAD, WAIT, DONE, state-encoding constants from the shared package.
REQ-006 IDLE: start_i with 1<=cfg_len_i<=C_MAX SHALL latch len, clear counters and err_len_o, go LOAD next cycle.
REQ-007 IDLE: start_i with cfg_len_i=0 or >C_MAX SHALL pulse err_cfg_o next cycle and remain IDLE.
REQ-008 start_i outside IDLE SHALL be ignored with no side effects.
REQ-009 LOAD: dn_tvalid_o=up_tvalid_i, up_tready_o=dn_tready_i, dn_tdata_o=up_tdata_i, combinational, zero latency.
REQ-010 LOAD: dn_tlast_o SHALL be 1 iff in_cnt_o==len-1, independent of up_tlast_i.
REQ-011 Accepted element (dn_tvalid_o&dn_tready_i) SHALL increment in_cnt_o; the len-th one SHALL move FSM to WAIT.
REQ-012 Accepted element where up_tlast_i!=dn_tlast_o SHALL set err_len_o; forwarding continues by count.
REQ-013 Outside LOAD, up_tready_o, dn_tvalid_o, dn_tlast_o SHALL be 0.
REQ-014 In LOAD and WAIT, each res_valid_i&res_ready_i SHALL increment out_cnt_o, saturating at len.
REQ-015 Result handshake observed with out_cnt_o==len, or in IDLE/DONE, SHALL set err_len_o.
REQ-016 WAIT: when out_cnt_o reaches len (including the cycle entering WAIT), go DONE.
REQ-017 WAIT: idle counter SHALL clear on each result handshake, else increment; reaching TIMEOUT SHALL pulse err_tmo_o and go IDLE.
REQ-018 DONE: done_o=1 for exactly that cycle, then IDLE; a start_i in DONE is ignored.
REQ-019 Simultaneous last input and result handshake SHALL both be counted in the same cycle.
REQ-020 Counter arithmetic SHALL be unsigned CNT_W-bit; no wrap (bounded by len).

Reset
REQ-021 On rst_n=0 at a clock edge, FSM SHALL go IDLE; counters, len, idle counter, all outputs SHALL be 0.
REQ-022 Reset mid-row (LOAD/WAIT) SHALL abort without done_o or error pulses; in-flight pipeline data is not flushed by this block.

Structure
REQ-023 Package softmax_pkg SHALL hold FSM state constants, C_MAX, CNT_W defaults.
REQ-024 Sub-module sm_watchdog (idle counter plus timeout compare) SHALL be instantiated once; rest is flat.

Verification
REQ-025 start len=4, 4 inputs, last with tlast, 4 results -> dn_tlast_o on 4th, done_o one cycle after 4th result, no errors.
REQ-026 start len=0, then len=1025 -> err_cfg_o pulse each time, busy_o stays 0.
REQ-027 len=3, upstream tlast on element 2 -> err_len_o set, 3 elements forwarded, dn_tlast_o on 3rd.
REQ-028 len=2, dn_tready_i toggled 1,0,1,0 -> no element lost or duplicated, in_cnt_o ends 2.
REQ-029 len=2, TIMEOUT=8, only 1 result -> err_tmo_o after 8 idle WAIT cycles, FSM IDLE, no done_o.
REQ-030 rst_n low during LOAD with in_cnt_o=5 -> next cycle all outputs 0, new start len=1 completes normally.
